// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller in front of a synchronous-read word memory.
// Store: 2 cycles, load: 3, misaligned/NOP: 1. Requests are taken only in IDLE; the response has no back-pressure.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic        is_load,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state;
  logic [5:0] op_code;
  logic [1:0] op_lane;
  logic       op_load;

  logic        st_ok, ld_ok, mis;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  assign req_ready = (state == IDLE);

  always_comb begin
    st_ok = is_store && !is_load &&
            (alucode == ALU_SB || alucode == ALU_SH || alucode == ALU_SW);
    ld_ok = is_load && !is_store &&
            (alucode == ALU_LB || alucode == ALU_LH || alucode == ALU_LW ||
             alucode == ALU_LBU || alucode == ALU_LHU);
    mis = 1'b0;
    if (st_ok || ld_ok) begin
      case (alucode)
        ALU_SH, ALU_LH, ALU_LHU: mis = addr[0];
        ALU_SW, ALU_LW:          mis = |addr[1:0];
        default:                 mis = 1'b0;
      endcase
    end
  end

  // Narrow stores replicate their data so the enabled lanes always see it.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = wdata;
    case (alucode)
      ALU_SB: begin
        st_we    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      ALU_SH: begin
        st_we    = 4'b0011 << addr[1:0];
        st_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{op_lane, 3'b000} +: 8];
    ld_half = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_code)
      ALU_LB:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      ALU_LBU: ld_fmt = {24'd0, ld_byte};
      ALU_LH:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      ALU_LHU: ld_fmt = {16'd0, ld_half};
      default: ld_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_code    <= '0;
      op_lane    <= '0;
      op_load    <= 1'b0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      misalign   <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      misalign   <= 1'b0;
      mem_we     <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_code <= alucode;
            op_lane <= addr[1:0];
            op_load <= ld_ok;
            if ((st_ok || ld_ok) && !mis) begin
              state    <= ACCESS;
              mem_addr <= {addr[31:2], 2'b00};
              if (st_ok) begin
                mem_we    <= st_we;
                mem_wdata <= st_wdata;
              end
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              misalign   <= mis;
              rdata      <= '0;
            end
          end
        end
        ACCESS: begin
          if (op_load) begin
            state <= WAIT;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            rdata      <= '0;
          end
        end
        WAIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          rdata      <= ld_fmt;
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 SHALL have ports: req_valid input 1 (request offered); req_ready output 1 (controller idle, can accept).
REQ-003 SHALL have ports: is_store input 1; is_load input 1; alucode input 6 (`ALU_* codes from define.vh); addr input 32 (byte address); wdata input 32 (store data, LSB-aligned).
REQ-004 SHALL have ports: resp_valid output 1 (one-cycle completion pulse); rdata output 32 (formatted load result); misalign output 1 (qualifies resp_valid).
REQ-005 SHALL have ports: mem_addr output 32 (word address, bits [1:0]=0); mem_we output 4 (byte-lane write enables, bit n = bits [8n+7:8n]); mem_wdata output 32; mem_rdata input 32 (synchronous read, valid one cycle after mem_addr).

Function
REQ-006 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-007 SHALL implement states IDLE, ACCESS, WAIT, RESP; transitions: IDLE->ACCESS on accepted legal load/store; IDLE->RESP on accepted misaligned or NOP request; ACCESS->RESP for store; ACCESS->WAIT for load; WAIT->RESP; RESP->IDLE.
REQ-008 SHALL register alucode, addr, wdata and the operation type at acceptance; input changes after acceptance SHALL have no effect.
REQ-009 SHALL classify as NOP: is_store and is_load both 0, both 1, is_store with alucode not SB/SH/SW, or is_load with alucode not LB/LH/LW/LBU/LHU.
REQ-010 SHALL flag misaligned: SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0; SB/LB/LBU never misaligned.
REQ-011 SHALL drive mem_addr = {addr[31:2],2'b00} during ACCESS; mem_addr holds its last value otherwise.
REQ-012 SHALL assert mem_we only in ACCESS for a store: SB = 4'b0001<<addr[1:0], SH = 4'b0011<<addr[1:0], SW = 4'b1111; mem_we = 0 in all other states.
REQ-013 SHALL drive mem_wdata during ACCESS: SB = wdata[7:0] replicated to all 4 lanes; SH = wdata[15:0] replicated to both halves; SW = wdata.
REQ-014 SHALL capture mem_rdata at the end of WAIT and format little-endian: LB/LBU select byte lane addr[1:0], LH/LHU select half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-015 SHALL pulse resp_valid for exactly one cycle (RESP state); no back-pressure exists on the response.
REQ-016 SHALL set rdata = formatted load data for loads, 0 for stores, NOP and misaligned; rdata holds until the next RESP.
REQ-017 SHALL set misalign = 1 with resp_valid for misaligned requests only, 0 otherwise; a misaligned or NOP request SHALL produce no mem_we activity.
REQ-018 Latency from the acceptance edge N: misaligned/NOP resp_valid in cycle N+1; store write in cycle N+1, resp_valid in N+2; load address in N+1, data in N+2, resp_valid in N+3.
REQ-019 SHALL ignore req_valid while not IDLE (req_ready=0); the next request is accepted no earlier than the edge ending RESP+1 (IDLE).

Reset
REQ-020 SHALL on rst=1 asynchronously enter IDLE and set req_ready=1 once rst is released, resp_valid=0, rdata=0, misalign=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-021 SHALL, on reset mid-operation (ACCESS/WAIT/RESP), drop mem_we to 0 immediately, abandon the request and emit no resp_valid.

Verification
REQ-022 SB addr=0x0000_0102, wdata=0x0000_00AB -> cycle N+1 mem_addr=0x0000_0100, mem_we=4'b0100, mem_wdata=0xABABABAB; resp_valid at N+2, rdata=0, misalign=0.
REQ-023 LB addr=0x0000_0203, mem_rdata=0x80FF_1234 -> mem_addr=0x0000_0200 at N+1; resp_valid at N+3, rdata=0xFFFF_FF80; same with LBU -> rdata=0x0000_0080.
REQ-024 LH addr=0x0000_0012 with mem_rdata=0x8001_7FFF -> rdata=0xFFFF_8001; LHU -> 0x0000_8001.
REQ-025 SW addr=0x0000_0006 -> resp_valid at N+1 with misalign=1, mem_we=0 throughout, rdata=0.
REQ-026 Back-to-back: req_valid held high with SW then LW to 0x0000_0040 -> second accepted only after RESP; LW returns the stored word; req_ready=0 for every non-IDLE cycle.
REQ-027 Assert rst during WAIT of a load -> no resp_valid, all outputs at reset values, next request after release completes normally.
